// File: rtl/pipeline_pkg.sv
// Shared definitions for the EX-stage operand forwarding / hazard logic.
//   REG_ADDR_W : register-number width
//   BYP_*      : bypass_ex select codes seen by the EX operand mux
//   shadow_t   : per-stage shadow of {wr_num, reg_write, mem_read}
package pipeline_pkg;

   localparam int REG_ADDR_W = 5;

   // Bit 2 picks WB over EX/MEM. Bits [1:0] pick the operand:
   // 10 = operand 1 (rs), 01 = operand 2 (rt; operand 1 for shifts).
   localparam logic [2:0] BYP_NONE  = 3'b000;
   localparam logic [2:0] BYP_A_MEM = 3'b010;
   localparam logic [2:0] BYP_A_WB  = 3'b110;
   localparam logic [2:0] BYP_B_MEM = 3'b001;
   localparam logic [2:0] BYP_B_WB  = 3'b101;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] wr_num;
      logic                  reg_write;
      logic                  mem_read;
   } shadow_t;

   localparam shadow_t SHADOW_EMPTY = '0;

endpackage

// File: rtl/hazard_match.sv
// Compares one decoding source register against one shadow pipeline stage.
//   src_used        : the ID instruction actually reads this source
//   src_num         : source register number
//   stage_wr_num    : destination register held by the stage
//   stage_reg_write : the stage will write the regfile
//   match           : the source needs the value produced by the stage
module hazard_match
   import pipeline_pkg::*;
(
   input  logic                  src_used,
   input  logic [REG_ADDR_W-1:0] src_num,
   input  logic [REG_ADDR_W-1:0] stage_wr_num,
   input  logic                  stage_reg_write,
   output logic                  match
);

   // Register 0 is hardwired, so a write to it is never a producer.
   assign match = src_used && stage_reg_write &&
                  (stage_wr_num == src_num) && (src_num != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the EX-stage ALU operand mux.
// Inputs : clk, rst (async, active-high), ID instruction fields
//          (id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_num,
//          id_reg_write, id_mem_read), flush, mem_stall.
// Outputs: stall_if_id / bubble_id_ex (combinational), bypass_ex
//          (registered into EX with the instruction), shadow EX/MEM and
//          MEM/WB destinations, saturating stall_count.
module fwd_hazard_ctrl #(
   parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic [REG_ADDR_W-1:0] id_wr_num,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   input  logic                  mem_stall,
   output logic                  stall_if_id,
   output logic                  bubble_id_ex,
   output logic [2:0]            bypass_ex,
   output logic [REG_ADDR_W-1:0] regfile_write_num_ex_mem,
   output logic [REG_ADDR_W-1:0] regfile_write_num_mem_wb,
   output logic [CNT_W-1:0]      stall_count
);

   import pipeline_pkg::*;

   // ID/EX needs the full shadow (mem_read drives load-use detection).
   // Beyond ID/EX a load's data is reachable through the bypass paths, so
   // the later stages only keep the destination and its write enable.
   shadow_t               idex_q, idex_d;
   logic [REG_ADDR_W-1:0] exmem_num_q, exmem_num_d;
   logic                  exmem_we_q, exmem_we_d;
   logic [REG_ADDR_W-1:0] memwb_num_q, memwb_num_d;
   logic                  memwb_we_q, memwb_we_d;
   logic [2:0]            bypass_q, bypass_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic       rs_m_idex, rs_m_exmem, rt_m_idex, rt_m_exmem;
   logic       load_use, dual_fwd, hazard_stall, issue;
   logic [2:0] byp_code;

   hazard_match u_rs_idex (
      .src_used(id_use_rs), .src_num(id_rs),
      .stage_wr_num(idex_q.wr_num), .stage_reg_write(idex_q.reg_write),
      .match(rs_m_idex)
   );
   hazard_match u_rs_exmem (
      .src_used(id_use_rs), .src_num(id_rs),
      .stage_wr_num(exmem_num_q), .stage_reg_write(exmem_we_q),
      .match(rs_m_exmem)
   );
   hazard_match u_rt_idex (
      .src_used(id_use_rt), .src_num(id_rt),
      .stage_wr_num(idex_q.wr_num), .stage_reg_write(idex_q.reg_write),
      .match(rt_m_idex)
   );
   hazard_match u_rt_exmem (
      .src_used(id_use_rt), .src_num(id_rt),
      .stage_wr_num(exmem_num_q), .stage_reg_write(exmem_we_q),
      .match(rt_m_exmem)
   );

   // A load sitting in ID/EX has no data yet when our instruction reaches EX.
   assign load_use = idex_q.mem_read && (rs_m_idex || rt_m_idex);
   // The select carries a single bypass, so two forwarded operands must wait
   // until at least one producer has retired into the regfile.
   assign dual_fwd = (rs_m_idex || rs_m_exmem) && (rt_m_idex || rt_m_exmem);

   assign hazard_stall = id_valid && !flush && !mem_stall && (load_use || dual_fwd);
   assign issue        = id_valid && !flush && !hazard_stall;

   assign stall_if_id  = hazard_stall;
   assign bubble_id_ex = hazard_stall;

   // Look one cycle ahead: ID/EX becomes EX/MEM, EX/MEM becomes WB.
   // The nearer stage is tested first so it wins.
   always_comb begin
      byp_code = BYP_NONE;
      if (rs_m_idex)       byp_code = BYP_A_MEM;
      else if (rs_m_exmem) byp_code = BYP_A_WB;
      else if (rt_m_idex)  byp_code = BYP_B_MEM;
      else if (rt_m_exmem) byp_code = BYP_B_WB;
   end

   always_comb begin
      idex_d      = idex_q;
      exmem_num_d = exmem_num_q;
      exmem_we_d  = exmem_we_q;
      memwb_num_d = memwb_num_q;
      memwb_we_d  = memwb_we_q;
      bypass_d    = bypass_q;
      cnt_d       = cnt_q;
      if (!mem_stall) begin
         exmem_num_d = idex_q.wr_num;
         exmem_we_d  = idex_q.reg_write;
         memwb_num_d = exmem_num_q;
         memwb_we_d  = exmem_we_q;
         if (issue) begin
            idex_d.wr_num    = id_wr_num;
            idex_d.reg_write = id_reg_write;
            idex_d.mem_read  = id_mem_read;
            bypass_d         = byp_code;
         end else begin
            // bubble, flush or empty ID slot
            idex_d   = SHADOW_EMPTY;
            bypass_d = BYP_NONE;
         end
         if (hazard_stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_q      <= SHADOW_EMPTY;
         exmem_num_q <= '0;
         exmem_we_q  <= 1'b0;
         memwb_num_q <= '0;
         memwb_we_q  <= 1'b0;
         bypass_q    <= BYP_NONE;
         cnt_q       <= '0;
      end else begin
         idex_q      <= idex_d;
         exmem_num_q <= exmem_num_d;
         exmem_we_q  <= exmem_we_d;
         memwb_num_q <= memwb_num_d;
         memwb_we_q  <= memwb_we_d;
         bypass_q    <= bypass_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bypass_ex                = bypass_q;
   assign regfile_write_num_ex_mem = exmem_we_q ? exmem_num_q : '0;
   assign regfile_write_num_mem_wb = memwb_we_q ? memwb_num_q : '0;
   assign stall_count              = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed instruction sequences
// followed by a randomized stream, checked against a small pipeline model.
module tb_fwd_hazard_ctrl;

   localparam int RW = 5;

   logic          clk;
   logic          rst;
   logic          id_valid;
   logic [RW-1:0] id_rs;
   logic [RW-1:0] id_rt;
   logic          id_use_rs;
   logic          id_use_rt;
   logic [RW-1:0] id_wr_num;
   logic          id_reg_write;
   logic          id_mem_read;
   logic          flush;
   logic          mem_stall;
   logic          stall_if_id;
   logic          bubble_id_ex;
   logic [2:0]    bypass_ex;
   logic [RW-1:0] regfile_write_num_ex_mem;
   logic [RW-1:0] regfile_write_num_mem_wb;
   logic [31:0]   stall_count;

   fwd_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_wr_num(id_wr_num), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .flush(flush), .mem_stall(mem_stall),
      .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
      .bypass_ex(bypass_ex),
      .regfile_write_num_ex_mem(regfile_write_num_ex_mem),
      .regfile_write_num_mem_wb(regfile_write_num_mem_wb),
      .stall_count(stall_count)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard / model ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [2:0]  exp_q[$];
   // index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB
   logic [RW-1:0] m_wr [3];
   logic          m_we [3];
   logic          m_ld [3];
   logic [2:0]    m_byp;
   logic [31:0]   m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < 3; s++) begin
         m_wr[s] = '0;
         m_we[s] = 1'b0;
         m_ld[s] = 1'b0;
      end
      m_byp = 3'b000;
      m_cnt = '0;
      exp_q.delete();
   endtask

   task automatic drive(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic urs, input logic urt, input logic [RW-1:0] wr,
                        input logic we, input logic ld, input logic fl, input logic ms);
      id_valid     = v;
      id_rs        = rs;
      id_rt        = rt;
      id_use_rs    = urs;
      id_use_rt    = urt;
      id_wr_num    = wr;
      id_reg_write = we;
      id_mem_read  = ld;
      flush        = fl;
      mem_stall    = ms;
   endtask

   // Asserts reset at the current time, checks the asynchronous clear,
   // then releases it just after the next rising edge.
   task automatic do_reset();
      rst = 1'b1;
      #2;
      check_eq("rst_bypass", bypass_ex, 0);
      check_eq("rst_wnum_ex_mem", regfile_write_num_ex_mem, 0);
      check_eq("rst_wnum_mem_wb", regfile_write_num_mem_wb, 0);
      check_eq("rst_stall_count", stall_count, 0);
      check_eq("rst_stall", stall_if_id, 0);
      check_eq("rst_bubble", bubble_id_ex, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   // One clock cycle: drive, check combinational outputs, advance the model,
   // queue the expected select, then compare registered outputs after the edge.
   task automatic step(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic urs, input logic urt, input logic [RW-1:0] wr,
                       input logic we, input logic ld, input logic fl, input logic ms,
                       output logic exp_stall, output logic obs_stall);
      logic rs0, rs1, rt0, rt1;
      logic [2:0] code;
      drive(v, rs, rt, urs, urt, wr, we, ld, fl, ms);
      rs0 = urs && m_we[0] && (m_wr[0] == rs) && (rs != '0);
      rs1 = urs && m_we[1] && (m_wr[1] == rs) && (rs != '0);
      rt0 = urt && m_we[0] && (m_wr[0] == rt) && (rt != '0);
      rt1 = urt && m_we[1] && (m_wr[1] == rt) && (rt != '0);
      exp_stall = v && !fl && !ms &&
                  ((m_ld[0] && (rs0 || rt0)) || ((rs0 || rs1) && (rt0 || rt1)));
      if (rs0)      code = 3'b010;
      else if (rs1) code = 3'b110;
      else if (rt0) code = 3'b001;
      else if (rt1) code = 3'b101;
      else          code = 3'b000;
      #3;
      obs_stall = stall_if_id;
      check_eq("stall_if_id", stall_if_id, exp_stall);
      check_eq("bubble_id_ex", bubble_id_ex, exp_stall);
      if (!ms) begin
         for (int s = 2; s > 0; s--) begin
            m_wr[s] = m_wr[s-1];
            m_we[s] = m_we[s-1];
            m_ld[s] = m_ld[s-1];
         end
         if (v && !fl && !exp_stall) begin
            m_wr[0] = wr;
            m_we[0] = we;
            m_ld[0] = ld;
            m_byp   = code;
         end else begin
            m_wr[0] = '0;
            m_we[0] = 1'b0;
            m_ld[0] = 1'b0;
            m_byp   = 3'b000;
         end
         if (exp_stall && (m_cnt != 32'hffff_ffff)) m_cnt = m_cnt + 32'd1;
      end
      exp_q.push_back(m_byp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) check_eq("queue_empty", 1, 0);
      else check_eq("bypass_ex", bypass_ex, exp_q.pop_front());
      check_eq("wnum_ex_mem", regfile_write_num_ex_mem, m_we[1] ? m_wr[1] : '0);
      check_eq("wnum_mem_wb", regfile_write_num_mem_wb, m_we[2] ? m_wr[2] : '0);
      check_eq("stall_count", stall_count, m_cnt);
   endtask

   // Presents an instruction until it issues (bounded).
   task automatic issue(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic urs, input logic urt, input logic [RW-1:0] wr,
                        input logic we, input logic ld);
      logic es, os;
      int guard;
      guard = 0;
      step(1'b1, rs, rt, urs, urt, wr, we, ld, 1'b0, 1'b0, es, os);
      while (es && guard < 4) begin
         step(1'b1, rs, rt, urs, urt, wr, we, ld, 1'b0, 1'b0, es, os);
         guard++;
      end
      if (es) check_eq("stall_bound", 1, 0);
   endtask

   task automatic op_r(input logic [RW-1:0] rd, input logic [RW-1:0] rs, input logic [RW-1:0] rt);
      issue(rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
   endtask

   task automatic op_lw(input logic [RW-1:0] rd, input logic [RW-1:0] base);
      issue(base, '0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
   endtask

   task automatic op_nop();
      logic es, os;
      step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, es, os);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic es, os;
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_clear();
      do_reset();

      // 1: add $3,$1,$2 ; sub $4,$3,$5 -> op1 from EX/MEM
      op_r(5'd3, 5'd1, 5'd2);
      step(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s1_no_stall", os, 0);
      check_eq("s1_bypass", bypass_ex, 3'b010);

      // 2: add $3 ; nop ; or $6,$7,$3 -> op2 from WB ; same with sll $8,$3,2
      do_reset();
      op_r(5'd3, 5'd1, 5'd2);
      op_nop();
      op_r(5'd6, 5'd7, 5'd3);
      check_eq("s2_or_bypass", bypass_ex, 3'b101);
      op_r(5'd3, 5'd1, 5'd2);
      op_nop();
      issue('0, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
      check_eq("s2_sll_bypass", bypass_ex, 3'b101);

      // 3: lw $3,0($1) ; add $4,$3,$1 -> one load-use stall then op1 from WB
      do_reset();
      op_lw(5'd3, 5'd1);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s3_stall", os, 1);
      check_eq("s3_bubble_bypass", bypass_ex, 3'b000);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s3_issue", os, 0);
      check_eq("s3_bypass", bypass_ex, 3'b110);
      check_eq("s3_count", stall_count, 1);

      // 4: add $3 ; add $4 ; add $5,$4,$3 -> dual stall, then op1 from WB
      do_reset();
      op_r(5'd3, 5'd1, 5'd2);
      op_r(5'd4, 5'd1, 5'd2);
      step(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s4_stall", os, 1);
      step(1'b1, 5'd4, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s4_issue", os, 0);
      check_eq("s4_bypass", bypass_ex, 3'b110);
      check_eq("s4_count", stall_count, 1);

      // 5a: register 0 never forwards
      do_reset();
      op_r(5'd0, 5'd1, 5'd2);
      step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s5_r0_stall", os, 0);
      check_eq("s5_r0_bypass", bypass_ex, 3'b000);
      // 5b: flush overrides a load-use hazard and empties ID/EX
      do_reset();
      op_lw(5'd3, 5'd1);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, es, os);
      check_eq("s5_flush_stall", os, 0);
      check_eq("s5_flush_bypass", bypass_ex, 3'b000);
      op_nop();
      check_eq("s5_flush_shadow", regfile_write_num_ex_mem, 0);
      check_eq("s5_flush_lw_wb", regfile_write_num_mem_wb, 3);

      // 6: mem_stall freezes scenario 3, then reset in the middle of a stall
      do_reset();
      op_r(5'd1, 5'd2, 5'd2);
      op_lw(5'd3, 5'd1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, es, os);
         check_eq("s6_frz_stall", os, 0);
         check_eq("s6_frz_bypass", bypass_ex, 3'b010);
         check_eq("s6_frz_wnum", regfile_write_num_ex_mem, 1);
         check_eq("s6_frz_count", stall_count, 0);
      end
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s6_stall", os, 1);
      check_eq("s6_count", stall_count, 1);
      step(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s6_bypass", bypass_ex, 3'b110);
      op_lw(5'd5, 5'd0);
      drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      #3;
      check_eq("s6_pre_rst_stall", stall_if_id, 1);
      do_reset();
      step(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, es, os);
      check_eq("s6_post_rst_stall", os, 0);
      check_eq("s6_post_rst_bypass", bypass_ex, 3'b000);

      // randomized stream over a few registers to provoke hazards
      do_reset();
      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 3) != 0),
              RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              RW'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
              es, os);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
